// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32 DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op_rem,
   input  logic             op_unsigned,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic             op_rem_q, op_rem_d;

   // Operand conditioning at accept time
   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic             div_by_zero, sign_ovf;

   assign dvd_neg     = !op_unsigned && dividend[WIDTH-1];
   assign dvs_neg     = !op_unsigned && divisor[WIDTH-1];
   assign dvd_mag     = dvd_neg ? (~dividend + ONE) : dividend;
   assign dvs_mag     = dvs_neg ? (~divisor + ONE) : divisor;
   assign div_by_zero = (divisor == '0);
   assign sign_ovf    = !op_unsigned && (dividend == MIN_NEG) && (divisor == ALL_ONE);

   // One restoring step: quot_q shifts dividend bits out of its MSB and quotient bits into its LSB
   logic [WIDTH:0]   shifted, diff;
   logic             fits;
   logic [WIDTH-1:0] step_rem, step_quot;
   logic [WIDTH-1:0] final_quot, final_rem;

   assign shifted    = {rem_q, quot_q[WIDTH-1]};
   assign diff       = shifted - {1'b0, dvsr_q};
   assign fits       = !diff[WIDTH];
   assign step_rem   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign step_quot  = {quot_q[WIDTH-2:0], fits};
   assign final_quot = neg_quot_q ? (~step_quot + ONE) : step_quot;
   assign final_rem  = neg_rem_q ? (~step_rem + ONE) : step_rem;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      dvsr_d     = dvsr_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      op_rem_d   = op_rem_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (div_by_zero) begin
                  result_d = op_rem ? dividend : ALL_ONE;
                  state_d  = DONE;
               end else if (sign_ovf) begin
                  result_d = op_rem ? '0 : MIN_NEG;
                  state_d  = DONE;
               end else begin
                  rem_d      = '0;
                  quot_d     = dvd_mag;
                  dvsr_d     = dvs_mag;
                  cnt_d      = CNT_TOP;
                  neg_quot_d = dvd_neg ^ dvs_neg;
                  neg_rem_d  = dvd_neg;
                  op_rem_d   = op_rem;
                  state_d    = CALC;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            rem_d  = step_rem;
            quot_d = step_quot;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               result_d = op_rem_q ? final_rem : final_quot;
               state_d  = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         quot_q     <= '0;
         dvsr_q     <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         op_rem_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         dvsr_q     <= dvsr_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         op_rem_q   <= op_rem_d;
      end
   end

   assign busy   = (state_q == CALC);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 divide/remainder unit for the RV32 core.
- Sits downstream of the register file, alongside the ALU. Consumes the two register read operands (rs1 value, rs2 value) and produces a 32-bit result that the writeback result mux selects.
- Replaces the single-cycle combinational DIV/REM path. Extends it with DIVU/REMU.
- Core holds PC and register write while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, width of the iteration counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  request: begin a division with the current operands
- op_rem  input  1  0 = return quotient (DIV/DIVU), 1 = return remainder (REM/REMU)
- op_unsigned  input  1  0 = signed (DIV/REM), 1 = unsigned (DIVU/REMU)
- dividend  input  WIDTH  rs1 value
- divisor  input  WIDTH  rs2 value
- busy  output  1  high while iterating; start is ignored while high
- done  output  1  one-cycle pulse; result valid in the same cycle
- result  output  WIDTH  quotient or remainder, registered; holds until next completion

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, internal quotient/remainder/counter registers cleared. Reset mid-operation aborts the division; no done pulse follows.
- States: IDLE, CALC, DONE. busy = (state==CALC); done = (state==DONE).
- Accept: start sampled high at edge k while state is IDLE or DONE.
  - dividend, divisor, op_rem and op_unsigned are captured at edge k. Later input changes have no effect.
  - start in CALC is ignored and not queued.
- Normal path, IDLE/DONE -> CALC at edge k:
  - Signed mode: operands are converted to magnitudes, and the sign of the quotient (sign(a) XOR sign(b)) and the sign of the remainder (sign(a)) are stored.
  - Counter loaded with WIDTH-1.
  - Each CALC edge performs one restoring step: shift the partial remainder left by one and bring in the next dividend MSB. If partial remainder >= |divisor|, subtract it and set the quotient bit to 1; otherwise the quotient bit is 0.
  - Counter decrements each step. At the edge that processes counter==0 (edge k+WIDTH), the FSM enters DONE.
  - On that same edge, result is loaded with the sign-corrected quotient or remainder, selected by op_rem.
- Latency: done is high during the cycle after edge k+WIDTH (k+32 for WIDTH=32). busy is high for exactly WIDTH cycles.
- Special cases are resolved without iterating (IDLE/DONE -> DONE at edge k; done high in the cycle after edge k+1's preceding edge, i.e. one cycle after accept):
  - divisor==0: quotient = all ones; remainder = dividend. Applies to both signed and unsigned.
  - Signed overflow (dividend==0x80000000, divisor==0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Signed rounding truncates toward zero; the remainder takes the sign of the dividend (RISC-V semantics).
- DONE -> IDLE on the next edge if start is low. DONE -> CALC (or DONE, for special cases) if start is high, giving back-to-back operation.
- result is not cleared by start. It changes only when entering DONE.
- done never asserts without a preceding accepted start.

Test Plan:
- Signed: start, dividend=100, divisor=7, op_rem=0 -> busy high 32 cycles, then done pulse with result=14. Repeat with op_rem=1 -> result=2.
- Signed negative: dividend=-100 (0xFFFFFF9C), divisor=7 -> DIV result=0xFFFFFFF2 (-14); REM result=0xFFFFFFFE (-2).
- Unsigned: dividend=0xFFFFFFFF, divisor=2, op_unsigned=1 -> DIVU=0x7FFFFFFF, REMU=1. Same operands signed -> DIV=0, REM=0xFFFFFFFF.
- Special cases:
  - dividend=5, divisor=0 -> done one cycle after accept; DIV=0xFFFFFFFF, REM=5, busy never high.
  - 0x80000000 / 0xFFFFFFFF signed -> DIV=0x80000000, REM=0.
- Handshake:
  - Start 100/7, then pulse start with 9/3 at cycle 5 of CALC -> ignored; result=14.
  - Start asserted in the DONE cycle with 9/3 -> second done 33 cycles later with result=3.
- Reset: assert reset at cycle 10 of CALC -> busy=0, done=0, result=0 on the next cycle; no done pulse afterwards. A fresh start of 100/7 then completes normally with result=14.
